// File: rtl/dcache_ctrl.sv
// dcache_ctrl: 1 KiB direct-mapped, write-back, write-allocate data cache controller
// with 32 lines of 256 bits and an IDLE / WRITEBACK / REFILL miss handler.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t r_state, w_next;
  logic [255:0] r_data [32];
  logic [21:0]  r_tag [32];
  logic [31:0]  r_valid, r_dirty;
  logic [21:0]  w_tag;
  logic [4:0]   w_idx;
  logic [2:0]   w_word;
  logic [255:0] w_line;
  logic         w_req, w_wr, w_hit, w_idle, w_wr_hit, w_fill, w_unused;
  assign w_tag    = cpu_addr_i[31:10];
  assign w_idx    = cpu_addr_i[9:5];
  assign w_word   = cpu_addr_i[4:2];
  assign w_line   = r_data[w_idx];
  assign w_req    = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_wr     = cpu_MemWrite_i;
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle   = r_state == IDLE;
  assign w_wr_hit = w_idle & w_req & w_hit & w_wr;
  assign w_fill   = (r_state == REFILL) & mem_ack_i;
  assign w_unused = ^cpu_addr_i[1:0];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end
  // Data and tags carry no reset; an asynchronous reset forces IDLE, so no fill can land mid-abort.
  always_ff @(posedge clk_i)
    if (w_wr_hit) begin
      r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_data_i;
    end else if (w_fill) begin
      r_data[w_idx] <= mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end
  always_comb begin
    w_next       = r_state;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (r_state)
      IDLE: begin
        cpu_stall_o = w_req & ~w_hit;
        cpu_data_o  = (w_req & w_hit & ~w_wr) ? w_line[{w_word, 5'b0} +: 32] : '0;
        if (w_req && !w_hit)
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[w_idx], w_idx, 5'b0};
        mem_data_o   = w_line;
        w_next       = mem_ack_i ? REFILL : WRITEBACK;
      end
      REFILL: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_idx, 5'b0};
        w_next       = mem_ack_i ? IDLE : REFILL;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule
